// File: rtl/sem_pipe_arbiter.sv
// Counting-semaphore front end: round-robin grant of KEYS tokens into a
// DEPTH-stage stall-able pipeline with token return on output handshake.
module sem_pipe_arbiter #(
  parameter  int N_CH   = 4,
  parameter  int ADDR_W = 4,
  parameter  int DATA_W = 8,
  parameter  int KEYS   = 2,
  parameter  int DEPTH  = 3,
  parameter  int CNT_W  = 8,
  localparam int CH_W   = $clog2(N_CH),
  localparam int KEY_W  = $clog2(KEYS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  output logic [N_CH-1:0]          gnt,
  input  logic                     ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [KEY_W-1:0]         keys_avail,
  output logic [CNT_W-1:0]         count
);

  // More tokens than stages can never be used, so cap the pool at DEPTH.
  localparam int KEYS_EFF = (KEYS > DEPTH) ? DEPTH : KEYS;

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CH_W-1:0]   ch_q   [DEPTH];
  logic [CH_W-1:0]   ch_d   [DEPTH];
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [KEY_W-1:0]  keys_q, keys_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   win;
  logic              found, stall, cmpl, grant;
  int                idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CH_W-1:0] ptr_next(input logic [CH_W-1:0] w);
    return (w == CH_W'(N_CH - 1)) ? '0 : w + 1'b1;
  endfunction

  assign stall = vld_q[DEPTH-1] & ~ready;
  assign cmpl  = vld_q[DEPTH-1] & ready;
  assign grant = ~rst & ~stall & (keys_q != '0) & found;

  // Round-robin search starting at the pointer, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr_q) + i) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    ch_d   = ch_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (!stall) begin
      vld_d[0]  = grant;
      addr_d[0] = req_addr[win*ADDR_W +: ADDR_W];
      data_d[0] = req_data[win*DATA_W +: DATA_W];
      ch_d[0]   = win;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        addr_d[k] = addr_q[k-1];
        data_d[k] = data_q[k-1];
        ch_d[k]   = ch_q[k-1];
      end
    end
    if (grant) ptr_d = ptr_next(win);
    // A token returned this cycle only becomes grantable next cycle.
    keys_d = keys_q - KEY_W'(grant) + KEY_W'(cmpl);
    if (cmpl) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ptr_q  <= '0;
      keys_q <= KEY_W'(KEYS_EFF);
      cnt_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        ch_q[k]   <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
      keys_q <= keys_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ch_q   <= ch_d;
    end
  end

  assign out_valid  = vld_q[DEPTH-1];
  assign out_addr   = addr_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];
  assign out_ch     = ch_q[DEPTH-1];
  assign keys_avail = keys_q;
  assign count      = cnt_q;

endmodule

// File: doc/sem_pipe_arbiter.md
Name: sem_pipe_arbiter

Overview:
Hardware counting-semaphore front end for a multi-channel fixed-depth transfer pipeline. N_CH requesters each present an ADDR/DATA pair and compete for one of KEYS tokens under round-robin arbitration. A granted transfer consumes a token and travels a DEPTH-stage pipeline to a single ready-gated output. The token returns on output handshake, and a saturating completion counter is kept.

Parameters:
N_CH, 4, number of requesting channels (>=2)
ADDR_W, 4, address width per transfer
DATA_W, 8, data width per transfer
KEYS, 2, semaphore tokens = max transfers in flight (1..DEPTH; values >DEPTH behave as DEPTH)
DEPTH, 3, pipeline stages from grant to output (>=1)
CNT_W, 8, completion counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req  in  N_CH  per-channel request; held with its addr/data until gnt
req_addr  in  N_CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
req_data  in  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
gnt  out  N_CH  one-hot or zero; combinational; request accepted at this edge
ready  in  1  downstream accepts output this cycle
out_valid  out  1  output stage holds a transfer
out_addr  out  ADDR_W  address of output transfer
out_data  out  DATA_W  data of output transfer
out_ch  out  clog2(N_CH)  originating channel
keys_avail  out  clog2(KEYS+1)  tokens currently free
count  out  CNT_W  completed transfers, saturating

Behaviour:
- Reset (synchronous, active-high) clears all stage valids. It sets keys_avail=KEYS, the round-robin pointer to 0, count=0, and out_addr/out_data/out_ch=0.
- gnt=0 while rst is high. Reset mid-operation discards all in-flight transfers and restores all tokens; no partial output.
- stall = out_valid & ~ready.
- When not stalled, every stage shifts one place each cycle. Bubbles shift too; there is no collapsing.
- When stalled, nothing moves; out_* and all stages hold their values exactly.
- Grant condition: !stall & keys_avail>0 & |req. At most one grant per cycle.
- Arbitration is round-robin: search starts at the pointer and wraps modulo N_CH. The winner's gnt bit is asserted.
- The winner's addr/data/ch are loaded into stage 0 valid at that edge. The pointer then becomes winner+1 mod N_CH.
- If no grant occurs, stage 0 loads a bubble (when not stalled). The pointer is unchanged.
- Latency: a grant at edge T gives out_valid from T+DEPTH-1 settle, i.e. the transfer is visible DEPTH cycles after the grant cycle, absent stalls. Each stall cycle adds one cycle.
- Completion = out_valid & ready at a rising edge. On completion, count increments unless it is all ones, and the token is returned.
- Token arithmetic is next = keys_avail - grant + completion. A grant and a completion in the same cycle leave keys_avail unchanged.
- keys_avail never exceeds KEYS and never goes below 0.
- A grant is allowed in the same cycle the last token is being returned only if keys_avail>0 beforehand. A token returned this cycle is usable next cycle.
- A requester dropping req before gnt is legal; no grant is issued for it.
- req_addr/req_data are sampled only on the granting edge.

Test Plan:
- Reset, then hold rst=1 for 2 cycles while req=4'b1111 -> gnt=0, keys_avail=2, count=0, out_valid=0.
- Single request, ch2, addr=4'hA, data=8'h5C, ready=1 -> gnt=4'b0100 for 1 cycle; out_valid for 1 cycle with addr=A, data=5C, ch=2 DEPTH cycles later; count=1; keys_avail goes 2→1→2.
- Fairness: req=4'b1111 held, ready=1 -> grants in order ch0,ch1,ch2,ch3,ch0. Never more than 2 in flight; keys_avail hits 0 and gnt=0 until a completion; count=4 after the 4th output handshake.
- Backpressure: 2 transfers in flight, then ready=0 for 5 cycles -> out_* frozen, no grants, keys_avail=0. After ready=1, outputs drain in order and keys_avail returns to 2.
- Simultaneous grant and completion with keys_avail=1 -> keys_avail stays 1 across that edge.
- Saturation (CNT_W=2 build): 5 completions -> count=3. Reset with 2 transfers in flight -> out_valid=0 and keys_avail=KEYS on the next cycle.
